// File: rtl/vector_pe_if.sv
// Beat/result bus for vector_pe: packed operand lanes, vector framing, and the
// registered dot-product result with its strobe and overflow flag.
interface vector_pe_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic [LANES*DATA_W-1:0] neuron;
    logic [LANES*DATA_W-1:0] weight;
    logic [1:0]              ctl;
    logic                    vld_i;
    logic [ACC_W-1:0]        result;
    logic                    vld_o;
    logic                    ovf;

    modport master (
        output neuron, weight, ctl, vld_i,
        input  result, vld_o, ovf
    );

    modport slave (
        input  neuron, weight, ctl, vld_i,
        output result, vld_o, ovf
    );
endinterface

// File: rtl/vector_pe.sv
// Pipelined signed dot-product engine: lane products, adder tree, accumulator, result register.
// Define VECTOR_PE_SAT_EN for a saturating accumulator with sticky overflow; otherwise it wraps.
module vector_pe #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    vector_pe_if.slave   bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
`ifdef VECTOR_PE_SAT_EN
    // Keep the beat sum exact so clamping sees the true value, even if it exceeds ACC_W.
    localparam int S2_W = (SUM_W > ACC_W) ? SUM_W : ACC_W;
    localparam logic signed [S2_W:0] ACC_MAX = {{(S2_W - ACC_W + 2){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [S2_W:0] ACC_MIN = ~ACC_MAX;
`else
    localparam int S2_W = ACC_W;
`endif

    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [PROD_W-1:0] r_prod [LANES];
    logic signed [S2_W-1:0]   w_sum;
    logic signed [S2_W-1:0]   r_sum;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_sticky_next;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_sticky;
    logic                     r_s1_vld, r_s1_first, r_s1_last;
    logic                     r_s2_vld, r_s2_first, r_s2_last;
    logic                     r_s3_last;
    logic [ACC_W-1:0]         r_result;
    logic                     r_ovf;
    logic                     r_vld_o;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = PROD_W'($signed(bus.neuron[DATA_W*(LANES-1-i) +: DATA_W]))
                      * PROD_W'($signed(bus.weight[DATA_W*(LANES-1-i) +: DATA_W]));
        end
    end

    // NOTE: combinational blocks use blocking '=' so each statement sees the previous
    // one; clocked blocks use '<=' so every register samples pre-edge values.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + S2_W'(r_prod[i]);
        end
    end

`ifdef VECTOR_PE_SAT_EN
    logic signed [S2_W:0] w_wide;
    logic                 w_sat;

    always_comb begin
        w_base        = r_s2_first ? '0 : r_acc;
        w_wide        = (S2_W + 1)'(w_base) + (S2_W + 1)'(r_sum);
        w_sat         = 1'b0;
        w_acc_next    = w_wide[ACC_W-1:0];
        if (w_wide > ACC_MAX) begin
            w_acc_next = ACC_MAX[ACC_W-1:0];
            w_sat      = 1'b1;
        end else if (w_wide < ACC_MIN) begin
            w_acc_next = ACC_MIN[ACC_W-1:0];
            w_sat      = 1'b1;
        end
        w_sticky_next = (r_s2_first ? 1'b0 : r_sticky) | w_sat;
    end
`else
    always_comb begin
        w_base        = r_s2_first ? '0 : r_acc;
        w_acc_next    = w_base + r_sum;
        w_sticky_next = 1'b0;
    end
`endif

    // NOTE: pure datapath registers carry no reset; the valid bits alone decide
    // whether their contents are ever consumed.
    always_ff @(posedge clk) begin
        if (bus.vld_i) begin
            r_prod <= w_prod;
        end
        if (r_s1_vld) begin
            r_sum <= w_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s3_last  <= 1'b0;
            r_acc      <= '0;
            r_sticky   <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_vld_o    <= 1'b0;
        end else begin
            // Framing bits are gated by vld_i so ctl on bubble cycles is inert.
            r_s1_vld   <= bus.vld_i;
            r_s1_first <= bus.vld_i & bus.ctl[0];
            r_s1_last  <= bus.vld_i & bus.ctl[1];
            r_s2_vld   <= r_s1_vld;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s3_last  <= r_s2_last;
            if (r_s2_vld) begin
                r_acc    <= w_acc_next;
                r_sticky <= w_sticky_next;
            end
            r_vld_o <= r_s3_last;
            if (r_s3_last) begin
                r_result <= r_acc;
                r_ovf    <= r_sticky;
            end
        end
    end

    assign bus.result = r_result;
    assign bus.vld_o  = r_vld_o;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_vector_pe.sv
// Self-checking bench for vector_pe: directed and random beats, reference model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_vector_pe;
    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam longint SAT_MAX = 64'sh7FFFFFFF;
    localparam longint SAT_MIN = -64'sh80000000;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        longint      cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;

    exp_t        exp_q[$];
    exp_t        mon_e;
    longint      m_acc;
    bit          m_sticky;
    logic [31:0] held_res;
    logic        held_ovf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vector_pe_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    vector_pe #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] splat(input logic [15:0] v);
        return {4{v}};
    endfunction

    // Reference: exact signed dot product, then clamp or wrap the running total.
    task automatic model_beat(input logic [63:0] nv, input logic [63:0] wv,
                              input logic [1:0] c, input longint edge_no);
        longint s;
        longint t;
        exp_t   e;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            s += longint'($signed(nv[16*(LANES-1-i) +: 16])) * longint'($signed(wv[16*(LANES-1-i) +: 16]));
        end
        if (c[0]) begin
            m_acc    = 0;
            m_sticky = 1'b0;
        end
        t = m_acc + s;
`ifdef VECTOR_PE_SAT_EN
        if (t > SAT_MAX) begin
            t = SAT_MAX;
            m_sticky = 1'b1;
        end else if (t < SAT_MIN) begin
            t = SAT_MIN;
            m_sticky = 1'b1;
        end
        m_acc = t;
`else
        m_acc = longint'($signed(t[31:0]));
`endif
        if (c[1]) begin
            e.res = m_acc[31:0];
            e.ovf = m_sticky;
            e.cyc = edge_no + 3;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [63:0] nv, input logic [63:0] wv,
                        input logic [1:0] c, input bit v);
        @(posedge clk);
        #1;
        bus.neuron = nv;
        bus.weight = wv;
        bus.ctl    = c;
        bus.vld_i  = v;
        if (v) model_beat(nv, wv, c, cyc + 1);
    endtask

    task automatic drain();
        send('0, '0, 2'b00, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        bus.vld_i = 1'b0;
        exp_q.delete();
        m_acc    = 0;
        m_sticky = 1'b0;
        held_res = '0;
        held_ovf = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_result", bus.result, 64'd0);
            check("rst_vld_o", bus.vld_o, 64'd0);
            check("rst_ovf", bus.ovf, 64'd0);
        end else if (bus.vld_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_vld_o: got pulse with result 0x%0h at cycle %0d, required none", bus.result, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", bus.result, mon_e.res);
                check("ovf", bus.ovf, mon_e.ovf);
                check("latency_cycle", cyc, mon_e.cyc);
                held_res = mon_e.res;
                held_ovf = mon_e.ovf;
            end
        end else begin
            check("hold_result", bus.result, held_res);
            check("hold_ovf", bus.ovf, held_ovf);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.neuron = '0;
        bus.weight = '0;
        bus.ctl    = 2'b00;
        do_reset(10);

        // Single-beat vector: 2+3+4+5.
        send(splat(16'd1), {16'd2, 16'd3, 16'd4, 16'd5}, 2'b11, 1'b1);
        drain();

        // Two back-to-back 32-beat vectors, no gap between them.
        for (int i = 0; i < 32; i++) send(splat(16'd1), splat(16'd1), {i == 31, i == 0}, 1'b1);
        for (int i = 0; i < 32; i++) send(splat(16'hFFFF), splat(16'd1), {i == 31, i == 0}, 1'b1);
        drain();

        // Bubbles carrying ctl=11 must be ignored.
        for (int i = 0; i < 8; i++) begin
            send(splat(16'd3), splat(16'hFFFE), {i == 7, i == 0}, 1'b1);
            if (i < 7) send({$urandom, $urandom}, {$urandom, $urandom}, 2'b11, 1'b0);
        end
        drain();

        // Overflow: saturates with the macro, wraps without it.
        send(splat(16'h7FFF), splat(16'h7FFF), 2'b01, 1'b1);
        send(splat(16'h7FFF), splat(16'h7FFF), 2'b10, 1'b1);
        drain();

        // Reset mid-vector, then a fresh vector.
        for (int i = 0; i < 5; i++) send(splat(16'd1), splat(16'd1), {1'b0, i == 0}, 1'b1);
        @(posedge clk);
        #1;
        do_reset(3);
        for (int i = 0; i < 4; i++) send(splat(16'd1), splat(16'd1), {i == 3, i == 0}, 1'b1);
        drain();

        // Beat without a first beat after reset accumulates onto zero.
        @(posedge clk);
        #1;
        do_reset(2);
        send(splat(16'd1), splat(16'd2), 2'b10, 1'b1);
        drain();

        // Random vectors with bubbles and occasional missing first beats.
        for (int v = 0; v < 40; v++) begin
            int  len;
            bit  skip_first;
            len        = $urandom_range(1, 6);
            skip_first = ($urandom_range(0, 7) == 0);
            for (int j = 0; j < len; j++) begin
                send({$urandom, $urandom}, {$urandom, $urandom},
                     {j == len - 1, (j == 0) && !skip_first}, 1'b1);
                if ($urandom_range(0, 3) == 0)
                    send({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'b0);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
